// File: rtl/watch_display_decoder_pkg.sv
// Shared constants for the stopwatch display readback decoder.
// Segment codes are active-low {dp,g,f,e,d,c,b,a} with dp shown high.
package watch_disp_pkg;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  localparam int TIME_MAX  = 599;
  localparam int TIME_W    = 10;
  localparam int ERR_CNT_W = 8;
  localparam int SAMPLE_W  = 26;

endpackage

// File: rtl/watch_display_decoder_seg7_to_bcd.sv
// Combinational 7-segment to BCD decoder; the decimal point is forced high
// before matching so it never affects the decoded digit.
module seg7_to_bcd
  import watch_disp_pkg::*;
(
  input  logic [7:0] i_code,
  output logic       o_legal,
  output logic [3:0] o_bcd
);

  logic [7:0] w_code;

  assign w_code = i_code | 8'h80;

  always_comb begin
    o_legal = 1'b1;
    o_bcd   = 4'd0;
    case (w_code)
      SEG_0:   o_bcd = 4'd0;
      SEG_1:   o_bcd = 4'd1;
      SEG_2:   o_bcd = 4'd2;
      SEG_3:   o_bcd = 4'd3;
      SEG_4:   o_bcd = 4'd4;
      SEG_5:   o_bcd = 4'd5;
      SEG_6:   o_bcd = 4'd6;
      SEG_7:   o_bcd = 4'd7;
      SEG_8:   o_bcd = 4'd8;
      SEG_9:   o_bcd = 4'd9;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/watch_display_decoder.sv
// Stopwatch display readback: deglitches the display bus, recovers BCD and
// binary time, checks count progression. Optional STALL_DET_EN adds an idle detector.
module watch_display_decoder
  import watch_disp_pkg::*;
#(
  parameter int STABLE_CYCLES = 2
`ifdef STALL_DET_EN
  ,
  parameter int STALL_CYC = 50000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [7:0] tensin,
  input  logic [7:0] onesin,
  input  logic [9:0] tenthsin,
  output logic       valid,
  output logic [3:0] tens_bcd,
  output logic [3:0] ones_bcd,
  output logic [3:0] tenths_bcd,
  output logic [9:0] time_t,
  output logic       evt_tick,
  output logic       err_seg,
  output logic       err_seq,
  output logic [7:0] err_cnt,
  output logic       stall
);

  localparam logic [3:0] STAB = 4'(STABLE_CYCLES);

  logic [SAMPLE_W-1:0]  w_in;
  logic [SAMPLE_W-1:0]  r_sample;
  logic [SAMPLE_W-1:0]  r_last_eval;
  logic [3:0]           r_stab_cnt;
  logic                 w_eval;

  logic                 w_tens_legal;
  logic                 w_ones_legal;
  logic                 w_tenths_legal;
  logic [3:0]           w_tens_bcd;
  logic [3:0]           w_ones_bcd;
  logic [3:0]           w_tenths_bcd;
  logic [9:0]           w_tenths_hot;
  logic                 w_seg_ok;
  logic [TIME_W-1:0]    w_time_new;
  logic [TIME_W-1:0]    w_time_succ;
  logic                 w_seq_bad;
  logic [ERR_CNT_W-1:0] w_cnt_base;
  logic [ERR_CNT_W-1:0] w_cnt_inc;

  logic                 r_valid;
  logic [3:0]           r_tens;
  logic [3:0]           r_ones;
  logic [3:0]           r_tenths;
  logic [TIME_W-1:0]    r_time;
  logic                 r_evt_tick;
  logic                 r_err_seg;
  logic                 r_err_seq;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  assign w_in = {tensin, onesin, tenthsin};

  // Counter saturates at STAB so a held value is evaluated exactly once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample   <= '0;
      r_stab_cnt <= 4'd0;
    end else if (w_in != r_sample) begin
      r_sample   <= w_in;
      r_stab_cnt <= 4'd1;
    end else if (r_stab_cnt != STAB) begin
      r_stab_cnt <= r_stab_cnt + 4'd1;
    end
  end

  assign w_eval = (r_stab_cnt == STAB) && (r_sample != r_last_eval);

  seg7_to_bcd u_tens (
    .i_code  (r_sample[25:18]),
    .o_legal (w_tens_legal),
    .o_bcd   (w_tens_bcd)
  );

  seg7_to_bcd u_ones (
    .i_code  (r_sample[17:10]),
    .o_legal (w_ones_legal),
    .o_bcd   (w_ones_bcd)
  );

  always_comb begin
    w_tenths_hot   = ~r_sample[9:0];
    w_tenths_legal = $onehot(w_tenths_hot);
    w_tenths_bcd   = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (w_tenths_hot[k]) w_tenths_bcd = 4'(k);
    end
  end

  assign w_seg_ok = w_tens_legal && w_ones_legal && w_tenths_legal && (w_tens_bcd <= 4'd5);

  assign w_time_new = (10'(w_tens_bcd) * 10'd100) + (10'(w_ones_bcd) * 10'd10)
                    + 10'(w_tenths_bcd);

  assign w_time_succ = (r_time == 10'(TIME_MAX)) ? '0 : r_time + 10'd1;

  // A reset to zero is always accepted; clear in the same cycle suppresses the check.
  assign w_seq_bad = r_valid && !clear && (w_time_new != w_time_succ) && (w_time_new != '0);

  assign w_cnt_base = clear ? '0 : r_err_cnt;
  assign w_cnt_inc  = (w_cnt_base == '1) ? '1 : w_cnt_base + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_eval <= '0;
      r_valid     <= 1'b0;
      r_tens      <= 4'd0;
      r_ones      <= 4'd0;
      r_tenths    <= 4'd0;
      r_time      <= '0;
      r_evt_tick  <= 1'b0;
      r_err_seg   <= 1'b0;
      r_err_seq   <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_evt_tick <= 1'b0;
      if (clear) begin
        r_err_seg <= 1'b0;
        r_err_seq <= 1'b0;
        r_err_cnt <= '0;
        r_valid   <= 1'b0;
      end
      if (w_eval) begin
        r_last_eval <= r_sample;
        if (!w_seg_ok) begin
          r_err_seg <= 1'b1;
          r_err_cnt <= w_cnt_inc;
        end else begin
          r_tens     <= w_tens_bcd;
          r_ones     <= w_ones_bcd;
          r_tenths   <= w_tenths_bcd;
          r_time     <= w_time_new;
          r_evt_tick <= 1'b1;
          r_valid    <= 1'b1;
          if (w_seq_bad) begin
            r_err_seq <= 1'b1;
            r_err_cnt <= w_cnt_inc;
          end
        end
      end
    end
  end

`ifdef STALL_DET_EN
  localparam logic [16:0] STALL_LIM = 17'(STALL_CYC);

  logic [16:0] r_idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle <= '0;
    end else if ((w_eval && w_seg_ok) || clear) begin
      r_idle <= '0;
    end else if (r_valid && (r_idle != STALL_LIM)) begin
      r_idle <= r_idle + 17'd1;
    end
  end

  assign stall = (r_idle == STALL_LIM);
`else
  assign stall = 1'b0;
`endif

  assign valid      = r_valid;
  assign tens_bcd   = r_tens;
  assign ones_bcd   = r_ones;
  assign tenths_bcd = r_tenths;
  assign time_t     = r_time;
  assign evt_tick   = r_evt_tick;
  assign err_seg    = r_err_seg;
  assign err_seq    = r_err_seq;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_watch_display_decoder.sv
// Bench for watch_display_decoder: directed scenarios plus randomized display
// traffic, checked every cycle against a reference model of the display rules.
module tb_watch_display_decoder;

  localparam int S = 2;
`ifdef STALL_DET_EN
  localparam int SC = 20;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [7:0] tensin;
  logic [7:0] onesin;
  logic [9:0] tenthsin;
  logic       valid;
  logic [3:0] tens_bcd;
  logic [3:0] ones_bcd;
  logic [3:0] tenths_bcd;
  logic [9:0] time_t;
  logic       evt_tick;
  logic       err_seg;
  logic       err_seq;
  logic [7:0] err_cnt;
  logic       stall;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // reference model state
  logic [25:0] hist [$];
  logic [25:0] m_last;
  bit          m_valid;
  int          m_tens, m_ones, m_tenths, m_time;
  bit          m_tick, m_eseg, m_eseq, m_stall;
  int          m_cnt;
  int          m_idle;

  watch_display_decoder #(
    .STABLE_CYCLES (S)
`ifdef STALL_DET_EN
    , .STALL_CYC   (SC)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .tensin     (tensin),
    .onesin     (onesin),
    .tenthsin   (tenthsin),
    .valid      (valid),
    .tens_bcd   (tens_bcd),
    .ones_bcd   (ones_bcd),
    .tenths_bcd (tenths_bcd),
    .time_t     (time_t),
    .evt_tick   (evt_tick),
    .err_seg    (err_seg),
    .err_seq    (err_seq),
    .err_cnt    (err_cnt),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  function automatic int seg_digit(logic [7:0] code);
    for (int i = 0; i < 10; i++) if ((code | 8'h80) == seg_tab[i]) return i;
    return -1;
  endfunction

  function automatic int tenths_digit(logic [9:0] v);
    int n = 0;
    int d = -1;
    for (int i = 0; i < 10; i++) if (!v[i]) begin n++; d = i; end
    return (n == 1) ? d : -1;
  endfunction

  function automatic logic [34:0] dut_vec();
    return {valid, tens_bcd, ones_bcd, tenths_bcd, time_t, evt_tick,
            err_seg, err_seq, err_cnt, stall};
  endfunction

  function automatic logic [34:0] mdl_vec();
    return {m_valid, 4'(m_tens), 4'(m_ones), 4'(m_tenths), 10'(m_time), m_tick,
            m_eseg, m_eseq, 8'(m_cnt), m_stall};
  endfunction

  task automatic model_reset();
    hist.delete();
    m_last = '0; m_valid = 0; m_tens = 0; m_ones = 0; m_tenths = 0; m_time = 0;
    m_tick = 0; m_eseg = 0; m_eseq = 0; m_cnt = 0; m_idle = 0; m_stall = 0;
  endtask

  // One clock of the display rules: a value seen S times in a row that differs
  // from the last judged value is judged now, using the clear seen this edge.
  task automatic model_update();
    logic [25:0] v;
    bit ev;
    int t, o, n, nt;
    m_tick = 0;
    ev = 0;
    if (hist.size() >= S) begin
      v  = hist[hist.size()-1];
      ev = (v != m_last);
      for (int i = 1; i < S; i++) if (hist[hist.size()-1-i] != v) ev = 0;
    end
    if (clear) begin m_eseg = 0; m_eseq = 0; m_cnt = 0; m_valid = 0; end
    if (ev) begin
      m_last = v;
      t = seg_digit(v[25:18]);
      o = seg_digit(v[17:10]);
      n = tenths_digit(v[9:0]);
      if (t < 0 || t > 5 || o < 0 || n < 0) begin
        m_eseg = 1;
        m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
      end else begin
        nt = t * 100 + o * 10 + n;
        if (m_valid && nt != (m_time + 1) % 600 && nt != 0) begin
          m_eseq = 1;
          m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
        m_tens = t; m_ones = o; m_tenths = n; m_time = nt;
        m_tick = 1; m_valid = 1;
      end
    end
`ifdef STALL_DET_EN
    if (m_tick || clear) m_idle = 0;
    else if (m_valid && m_idle < SC) m_idle++;
    m_stall = (m_idle >= SC);
`else
    m_stall = 0;
`endif
    hist.push_back({tensin, onesin, tenthsin});
    if (hist.size() > S) void'(hist.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_update();
    @(negedge clk);
  endtask

  task automatic drive(logic [7:0] t, logic [7:0] o, logic [9:0] n);
    tensin = t; onesin = o; tenthsin = n;
  endtask

  task automatic set_time(int tt);
    drive(seg_tab[tt/100], seg_tab[(tt/10)%10], ~(10'd1 << (tt%10)));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear = 1'b0;
    set_time(123);
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (dut_vec() !== 35'h0) begin
        miscompares++;
        $display("FAIL reset: outputs=%h required=0", dut_vec());
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_first_value();
    drive(8'hC0, 8'hC0, 10'h3FE);
    for (int k = 1; k <= 5; k++) begin
      step();
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL first_value cyc%0d: dut=%h model=%h", k, dut_vec(), mdl_vec());
      end
      vectors++;
      if ({evt_tick, valid} !== ((k == 3) ? 2'b11 : (k > 3) ? 2'b01 : 2'b00)) begin
        miscompares++;
        $display("FAIL first_latency cyc%0d: tick,valid=%b%b", k, evt_tick, valid);
      end
    end
  endtask

  task automatic test_wrap();
    int vals [3] = '{598, 599, 0};
    int ticks = 0;
    for (int i = 0; i < 3; i++) begin
      set_time(vals[i]);
      clear = (i == 0);
      for (int c = 0; c < 4; c++) begin
        step();
        clear = 1'b0;
        ticks += int'(evt_tick);
        vectors++;
        if (dut_vec() !== mdl_vec()) begin
          miscompares++;
          $display("FAIL wrap: dut=%h model=%h", dut_vec(), mdl_vec());
        end
      end
      vectors++;
      if (time_t !== 10'(vals[i])) begin
        miscompares++;
        $display("FAIL wrap_time: got %0d required %0d", time_t, vals[i]);
      end
    end
    vectors++;
    if (ticks != 3 || err_seq !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_ticks: ticks=%0d err_seq=%b required 3/0", ticks, err_seq);
    end
  endtask

  task automatic test_seq_err_clear();
    int vals [2] = '{12, 15};
    for (int i = 0; i < 2; i++) begin
      set_time(vals[i]);
      clear = (i == 0);
      for (int c = 0; c < 4; c++) begin
        step();
        clear = 1'b0;
        vectors++;
        if (dut_vec() !== mdl_vec()) begin
          miscompares++;
          $display("FAIL seq_err: dut=%h model=%h", dut_vec(), mdl_vec());
        end
      end
    end
    vectors++;
    if ({err_seq, err_cnt, time_t} !== {1'b1, 8'd1, 10'd15}) begin
      miscompares++;
      $display("FAIL seq_err_flags: seq=%b cnt=%0d t=%0d required 1/1/15", err_seq, err_cnt, time_t);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    vectors++;
    if ({err_seq, err_cnt, valid} !== {1'b0, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL seq_clear: seq=%b cnt=%0d valid=%b required 0/0/0", err_seq, err_cnt, valid);
    end
  endtask

  task automatic test_seg_err();
    int ticks = 0;
    set_time(16);
    for (int c = 0; c < 3; c++) step();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(seg_tab[0], seg_tab[1], 10'h3FC);
      else if (i == 1) drive(8'h82, seg_tab[1], ~(10'd1 << 6));
      else set_time(17);
      for (int c = 0; c < 3; c++) begin
        step();
        if (i < 2) ticks += int'(evt_tick);
        vectors++;
        if (dut_vec() !== mdl_vec()) begin
          miscompares++;
          $display("FAIL seg_err: dut=%h model=%h", dut_vec(), mdl_vec());
        end
      end
      if (i < 2) begin
        vectors++;
        if ({err_seg, err_cnt, time_t} !== {1'b1, 8'(i + 1), 10'd16} || ticks != 0) begin
          miscompares++;
          $display("FAIL seg_err_hold%0d: seg=%b cnt=%0d t=%0d ticks=%0d", i, err_seg, err_cnt, time_t, ticks);
        end
      end
    end
    vectors++;
    if ({time_t, err_seq} !== {10'd17, 1'b0}) begin
      miscompares++;
      $display("FAIL seg_recover: t=%0d seq=%b required 17/0", time_t, err_seq);
    end
  endtask

  task automatic test_glitch();
    int ticks = 0;
    drive(8'hF9, seg_tab[1], ~(10'd1 << 7));
    step();
    set_time(17);
    for (int c = 0; c < 5; c++) begin
      step();
      ticks += int'(evt_tick);
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL glitch: dut=%h model=%h", dut_vec(), mdl_vec());
      end
    end
    vectors++;
    if (ticks != 0 || err_cnt !== 8'd2) begin
      miscompares++;
      $display("FAIL glitch_quiet: ticks=%0d cnt=%0d required 0/2", ticks, err_cnt);
    end
  endtask

  task automatic test_clear_coincide();
    for (int i = 0; i < 2; i++) begin
      if (i == 0) set_time(30);
      else drive(seg_tab[0], seg_tab[3], 10'h3FC);
      step();
      step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL clear_eval%0d: dut=%h model=%h", i, dut_vec(), mdl_vec());
      end
      vectors++;
      if (i == 0 && {valid, evt_tick, err_seq, err_seg, err_cnt, time_t} !== {4'b1100, 8'd0, 10'd30}) begin
        miscompares++;
        $display("FAIL clear_legal: v=%b tk=%b seq=%b seg=%b cnt=%0d t=%0d", valid, evt_tick, err_seq, err_seg, err_cnt, time_t);
      end else if (i == 1 && {valid, evt_tick, err_seg, err_cnt, time_t} !== {3'b001, 8'd1, 10'd30}) begin
        miscompares++;
        $display("FAIL clear_seg: v=%b tk=%b seg=%b cnt=%0d t=%0d", valid, evt_tick, err_seg, err_cnt, time_t);
      end
    end
  endtask

  task automatic test_saturation();
    for (int e = 0; e < 257; e++) begin
      set_time((e % 2) ? 15 : 12);
      clear = (e == 0);
      for (int c = 0; c < 3; c++) begin
        step();
        clear = 1'b0;
        vectors++;
        if (dut_vec() !== mdl_vec()) begin
          miscompares++;
          $display("FAIL saturation e%0d: dut=%h model=%h", e, dut_vec(), mdl_vec());
        end
      end
    end
    vectors++;
    if ({err_cnt, err_seq} !== {8'hFF, 1'b1}) begin
      miscompares++;
      $display("FAIL saturation_cnt: cnt=%0d seq=%b required 255/1", err_cnt, err_seq);
    end
  endtask

  task automatic test_reset_mid_window();
    set_time(40);
    step();
    reset = 1'b1;
    step();
    vectors++;
    if (dut_vec() !== 35'h0) begin
      miscompares++;
      $display("FAIL mid_reset: outputs=%h required=0", dut_vec());
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL mid_reset_run: dut=%h model=%h", dut_vec(), mdl_vec());
      end
    end
    vectors++;
    if ({valid, time_t, err_seq, err_cnt} !== {1'b1, 10'd40, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL mid_reset_first: v=%b t=%0d seq=%b cnt=%0d", valid, time_t, err_seq, err_cnt);
    end
  endtask

`ifdef STALL_DET_EN
  task automatic test_stall();
    set_time(100);
    for (int c = 1; c <= 23; c++) begin
      step();
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL stall: dut=%h model=%h", dut_vec(), mdl_vec());
      end
      if (c >= 22) begin
        vectors++;
        if (stall !== (c == 23)) begin
          miscompares++;
          $display("FAIL stall_edge c%0d: stall=%b", c, stall);
        end
      end
    end
    set_time(101);
    for (int c = 0; c < 3; c++) step();
    vectors++;
    if ({evt_tick, stall} !== 2'b10) begin
      miscompares++;
      $display("FAIL stall_drop: tick=%b stall=%b required 1/0", evt_tick, stall);
    end
  endtask
`endif

  task automatic test_random();
    int t = 0;
    for (int u = 0; u < 300; u++) begin
      int r    = $urandom_range(0, 99);
      int hold = $urandom_range(1, 4);
      if (r < 70) begin t = (t + 1) % 600; set_time(t); end
      else if (r < 80) begin t = 0; set_time(0); end
      else if (r < 90) begin t = $urandom_range(0, 599); set_time(t); end
      else drive(8'($urandom), 8'($urandom), 10'($urandom));
      clear = ($urandom_range(0, 19) == 0);
      for (int h = 0; h < hold; h++) begin
        step();
        clear = 1'b0;
        vectors++;
        if (dut_vec() !== mdl_vec()) begin
          miscompares++;
          $display("FAIL random u%0d: dut=%h model=%h", u, dut_vec(), mdl_vec());
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    drive(8'hFF, 8'hFF, 10'h3FF);
    model_reset();
    @(negedge clk);
    test_reset();
    test_first_value();
    test_wrap();
    test_seq_err_clear();
    test_seg_err();
    test_glitch();
    test_clear_coincide();
    test_saturation();
    test_reset_mid_window();
`ifdef STALL_DET_EN
    test_stall();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
